// File: rtl/axi_write_if.sv
// axi_write_if: AXI4 write address, data and response channels
interface axi_write_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0] aw_len;
  logic [2:0] aw_size;
  logic [1:0] aw_burst;
  logic [ID_WIDTH-1:0] aw_id;
  logic aw_valid, aw_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic w_last, w_valid, w_ready;
  logic [ID_WIDTH-1:0] b_id;
  logic [1:0] b_resp;
  logic b_valid, b_ready;
  modport master(
    output aw_addr, aw_len, aw_size, aw_burst, aw_id, aw_valid, w_data, w_strb, w_last, w_valid, b_ready,
    input aw_ready, w_ready, b_id, b_resp, b_valid
  );
  modport slave(
    input aw_addr, aw_len, aw_size, aw_burst, aw_id, aw_valid, w_data, w_strb, w_last, w_valid, b_ready,
    output aw_ready, w_ready, b_id, b_resp, b_valid
  );
endinterface

// File: rtl/axi_write_responder.sv
// axi_write_responder: AXI4 write subordinate with byte-strobed memory, one burst in flight,
// optional LFSR ready stalls and a registered debug read port.
module axi_write_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 8,
  parameter int MEM_DEPTH = 1024,
  parameter bit STALL_ENABLE = 0,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input logic clk,
  input logic rst_n,
  axi_write_if.slave axi,
  input logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int SB = $clog2(NB);
  localparam int MW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n, step, bound, word;
  logic [7:0] len;
  logic [2:0] size;
  logic [1:0] burst;
  logic [ID_WIDTH-1:0] id;
  logic [8:0] cnt;
  logic [15:0] lfsr;
  logic err, aw_err, oob, over, early, stall, aw_hs, w_hs, we;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  assign stall = STALL_ENABLE && lfsr[1:0] == 2'b00;
  assign aw_hs = axi.aw_valid && axi.aw_ready;
  assign w_hs = axi.w_valid && axi.w_ready;
  assign aw_err = axi.aw_size > 3'(SB) || axi.aw_burst == 2'd3 ||
    (axi.aw_burst == 2'd2 && !(axi.aw_len == 8'd1 || axi.aw_len == 8'd3 || axi.aw_len == 8'd7 || axi.aw_len == 8'd15)) ||
    (axi.aw_burst == 2'd2 && (axi.aw_addr & ((ADDR_WIDTH'(1) << axi.aw_size) - ADDR_WIDTH'(1))) != '0);
  assign step = ADDR_WIDTH'(1) << size;
  assign bound = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
  // wrap keeps the bits above the boundary and rolls the offset within it
  assign addr_n = burst == 2'd0 ? addr :
                  burst == 2'd1 ? (addr & ~(step - ADDR_WIDTH'(1))) + step :
                  (addr & ~(bound - ADDR_WIDTH'(1))) | ((addr + step) & (bound - ADDR_WIDTH'(1)));
  assign word = addr >> SB;
  assign oob = word >= ADDR_WIDTH'(MEM_DEPTH);
  assign over = cnt > {1'b0, len};
  assign early = axi.w_last && cnt < {1'b0, len};
  assign we = w_hs && !err && !oob && !over;
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_n;
  always_comb
    state_n = state == IDLE ? (aw_hs ? DATA : IDLE) :
              state == DATA ? (w_hs && axi.w_last ? RESP : DATA) :
              (axi.b_ready ? IDLE : RESP);
  always_comb begin
    axi.aw_ready = rst_n && state == IDLE && !stall;
    axi.w_ready = rst_n && state == DATA && !stall;
    axi.b_valid = state == RESP;
    axi.b_id = id;
    axi.b_resp = state == RESP && err ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      addr <= '0;
      len <= '0;
      size <= '0;
      burst <= '0;
      id <= '0;
      cnt <= '0;
      err <= 1'b0;
      lfsr <= STALL_SEED;
      dbg_data <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      dbg_data <= mem[dbg_addr];
      if (aw_hs) begin
        addr <= axi.aw_addr;
        len <= axi.aw_len;
        size <= axi.aw_size;
        burst <= axi.aw_burst;
        id <= axi.aw_id;
        cnt <= '0;
        err <= aw_err;
      end else if (w_hs) begin
        addr <= addr_n;
        cnt <= cnt[8] ? cnt : cnt + 9'd1;
        err <= err || oob || over || early;
      end
    end
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < NB; i++)
        if (axi.w_strb[i]) mem[word[MW-1:0]][8*i +: 8] <= axi.w_data[8*i +: 8];
endmodule

// File: tb/tb_axi_write_responder.sv
// tb_axi_write_responder: directed bursts against the responder with stall injection enabled
module tb_axi_write_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] dbg_addr;
  logic [31:0] dbg_data;
  logic [15:0] lfsr_m;
  logic [31:0] wd [16];
  logic [3:0] ws [16];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  axi_write_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(8)) axi ();
  axi_write_responder #(.MEM_DEPTH(1024), .STALL_ENABLE(1), .STALL_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .axi(axi), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  always @(posedge clk)
    lfsr_m <= !rst_n ? 16'hACE1 : {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] bt, input logic [7:0] i);
    axi.aw_addr = a;
    axi.aw_len = l;
    axi.aw_size = s;
    axi.aw_burst = bt;
    axi.aw_id = i;
    axi.aw_valid = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      chk("aw_ready", axi.aw_ready, lfsr_m[1:0] != 2'b00);
      if (axi.aw_ready) break;
      if (n == 29) chk("aw_timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    axi.aw_valid = 1'b0;
  endtask
  task automatic do_w(input logic [31:0] d, input logic [3:0] st, input logic last);
    axi.w_data = d;
    axi.w_strb = st;
    axi.w_last = last;
    axi.w_valid = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (n == 0) chk("b_valid_early", axi.b_valid, 0);
      chk("w_ready", axi.w_ready, lfsr_m[1:0] != 2'b00);
      if (axi.w_ready) break;
      if (n == 29) chk("w_timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    axi.w_valid = 1'b0;
    axi.w_last = 1'b0;
  endtask
  task automatic burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] bt,
                       input logic [7:0] i, input int nb, input logic [1:0] resp, input int hold);
    do_aw(a, l, s, bt, i);
    for (int n = 0; n < nb; n++) do_w(wd[n], ws[n], n == nb - 1);
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      chk("b_valid", axi.b_valid, 1);
      chk("b_id", axi.b_id, i);
      chk("b_resp", axi.b_resp, resp);
      chk("aw_ready_resp", axi.aw_ready, 0);
      if (h < hold) begin
        @(posedge clk);
        #1;
      end
    end
    axi.b_ready = 1'b1;
    @(posedge clk);
    #1;
    axi.b_ready = 1'b0;
  endtask
  task automatic rd(input logic [9:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("mem%0d", idx), dbg_data, exp);
    @(posedge clk);
    #1;
  endtask
  initial begin
    {axi.aw_addr, axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_id, axi.aw_valid} = '0;
    {axi.w_data, axi.w_strb, axi.w_last, axi.w_valid, axi.b_ready} = '0;
    dbg_addr = '0;
    for (int n = 0; n < 16; n++) ws[n] = 4'hF;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_aw_ready", axi.aw_ready, 0);
    chk("rst_w_ready", axi.w_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_aw_ready", axi.aw_ready, lfsr_m[1:0] != 2'b00);
    chk("post_rst_b_valid", axi.b_valid, 0);
    chk("post_rst_b_resp", axi.b_resp, 0);
    chk("post_rst_b_id", axi.b_id, 0);
    chk("post_rst_dbg", dbg_data, 0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 9; n++) wd[n] = n == 0 ? 32'h12345678 : 32'h0;
    burst(32'h0, 8'd8, 3'd2, 2'd1, 8'h01, 9, 2'b00, 0);
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    burst(32'h10, 8'd3, 3'd2, 2'd1, 8'h05, 4, 2'b00, 0);
    rd(4, 32'h11); rd(5, 32'h22); rd(6, 32'h33); rd(7, 32'h44);
    wd[0] = 32'hA1; wd[1] = 32'hA2; wd[2] = 32'hA3; wd[3] = 32'hA4;
    burst(32'h38, 8'd3, 3'd2, 2'd2, 8'h07, 4, 2'b00, 0);
    rd(14, 32'hA1); rd(15, 32'hA2); rd(12, 32'hA3); rd(13, 32'hA4);
    wd[0] = 32'hB1; wd[1] = 32'hB2; wd[2] = 32'hB3;
    burst(32'h38, 8'd2, 3'd2, 2'd2, 8'h08, 3, 2'b10, 0);
    rd(14, 32'hA1); rd(15, 32'hA2); rd(12, 32'hA3);
    wd[0] = 32'hAABBCCDD; wd[1] = 32'hAABBCCDD; wd[2] = 32'hAABBCCDD;
    ws[0] = 4'h1; ws[1] = 4'h2; ws[2] = 4'h4;
    burst(32'h20, 8'd2, 3'd2, 2'd0, 8'h09, 3, 2'b00, 0);
    rd(8, 32'h00BBCCDD);
    for (int n = 0; n < 16; n++) ws[n] = 4'hF;
    wd[0] = 32'h5A0; wd[1] = 32'h5A1;
    burst(32'h40, 8'd3, 3'd2, 2'd1, 8'h0A, 2, 2'b10, 0);
    wd[0] = 32'h55; wd[1] = 32'h66; wd[2] = 32'h77; wd[3] = 32'h88;
    burst(32'h10, 8'd1, 3'd2, 2'd1, 8'h0B, 4, 2'b10, 0);
    rd(4, 32'h55); rd(5, 32'h66); rd(6, 32'h33); rd(7, 32'h44);
    wd[0] = 32'hDEADBEEF;
    burst(32'h1000, 8'd0, 3'd2, 2'd1, 8'h0C, 1, 2'b10, 5);
    rd(0, 32'h12345678);
    burst(32'h60, 8'd0, 3'd3, 2'd1, 8'h0D, 1, 2'b10, 0);
    axi.w_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("idle_w_ready", axi.w_ready, 0);
      @(posedge clk);
      #1;
    end
    axi.w_valid = 1'b0;
    wd[0] = 32'hCAFE0001;
    burst(32'h50, 8'd0, 3'd2, 2'd1, 8'h0E, 1, 2'b00, 0);
    dbg_addr = 10'd20;
    do_aw(32'h50, 8'd0, 3'd2, 2'd1, 8'h0F);
    do_w(32'hCAFE0002, 4'hF, 1'b1);
    @(negedge clk);
    chk("dbg_same_edge", dbg_data, 32'hCAFE0001);
    chk("b_id_dbg", axi.b_id, 8'h0F);
    axi.b_ready = 1'b1;
    @(posedge clk);
    #1;
    axi.b_ready = 1'b0;
    @(negedge clk);
    chk("dbg_next", dbg_data, 32'hCAFE0002);
    @(posedge clk);
    #1;
    do_aw(32'h80, 8'd3, 3'd2, 2'd1, 8'h10);
    do_w(32'h77, 4'hF, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_aw_ready", axi.aw_ready, 0);
    chk("midrst_w_ready", axi.w_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", axi.aw_ready, lfsr_m[1:0] != 2'b00);
    chk("midrst_b_valid", axi.b_valid, 0);
    chk("midrst_b_id", axi.b_id, 0);
    chk("midrst_w_ready_after", axi.w_ready, 0);
    @(posedge clk);
    #1;
    rd(32, 32'h77);
    for (int k = 0; k < 20; k++) begin
      wd[0] = 32'h1000_0000 | k;
      wd[1] = 32'h2000_0000 | k;
      burst(32'h200 + 32'(8 * k), 8'd1, 3'd2, 2'd1, 8'(k), 2, 2'b00, 0);
    end
    for (int k = 0; k < 20; k++) begin
      rd(10'(128 + 2 * k), 32'h1000_0000 | k);
      rd(10'(129 + 2 * k), 32'h2000_0000 | k);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
